// File: rtl/sw_datapath.sv
// Multi-cycle store-word datapath: fetch, decode, address add, then a req/ack store
// to data memory with an abort timer.
//
// state    | meaning
// S_FETCH  | idle; latch inst_i into IR when en=1
// S_DECODE | check opcode, read base (A) and store data (B) from register file
// S_EXEC   | ALUOut = A + signext(imm), arm store timer
// S_MEM    | hold dm_req until dm_ack or timer expiry
module sw_datapath #(
  parameter int PC_W    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  output logic [PC_W-1:0] pc_o,
  input  logic [31:0]     inst_i,
  input  logic            rf_we,
  input  logic [4:0]      rf_waddr,
  input  logic [31:0]     rf_wdata,
  output logic            dm_req,
  output logic [31:0]     dm_addr,
  output logic [31:0]     dm_wdata,
  input  logic            dm_ack,
  output logic            busy,
  output logic            illegal,
  output logic            timeout,
  output logic [15:0]     store_cnt
);

  localparam logic [5:0] OP_SW = 6'b101011;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM} state_t;

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc;
  logic [31:0]     ir, a, b, alu_out;
  logic [TW-1:0]   tmr;
  logic [31:0]     rf [0:31];
  logic [31:0]     rs_val, rt_val;
  logic            ir_load, ab_load, alu_load, tmr_load;
  logic            pc_inc, cnt_inc, illegal_nxt, timeout_nxt;

  // Entry 0 is never written; reads of index 0 are forced to zero instead.
  always_ff @(posedge clk) begin
    if (rf_we && (rf_waddr != 5'd0))
      rf[rf_waddr] <= rf_wdata;
  end

  assign rs_val = (ir[25:21] == 5'd0) ? 32'd0 : rf[ir[25:21]];
  assign rt_val = (ir[20:16] == 5'd0) ? 32'd0 : rf[ir[20:16]];

  always_comb begin
    state_nxt   = state;
    ir_load     = 1'b0;
    ab_load     = 1'b0;
    alu_load    = 1'b0;
    tmr_load    = 1'b0;
    pc_inc      = 1'b0;
    cnt_inc     = 1'b0;
    illegal_nxt = 1'b0;
    timeout_nxt = 1'b0;
    case (state)
      S_FETCH: begin
        if (en) begin
          ir_load   = 1'b1;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        if (ir[31:26] != OP_SW) begin
          illegal_nxt = 1'b1;
          pc_inc      = 1'b1;
          state_nxt   = S_FETCH;
        end else begin
          ab_load   = 1'b1;
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_load  = 1'b1;
        tmr_load  = 1'b1;
        state_nxt = S_MEM;
      end
      S_MEM: begin
        // An ack on the last allowed cycle still completes the store.
        if (dm_ack) begin
          pc_inc    = 1'b1;
          cnt_inc   = 1'b1;
          state_nxt = S_FETCH;
        end else if (tmr == '0) begin
          timeout_nxt = 1'b1;
          pc_inc      = 1'b1;
          state_nxt   = S_FETCH;
        end
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_FETCH;
      pc        <= '0;
      ir        <= '0;
      a         <= '0;
      b         <= '0;
      alu_out   <= '0;
      tmr       <= '0;
      illegal   <= 1'b0;
      timeout   <= 1'b0;
      store_cnt <= '0;
    end else begin
      state   <= state_nxt;
      illegal <= illegal_nxt;
      timeout <= timeout_nxt;
      if (ir_load)  ir <= inst_i;
      if (ab_load) begin
        a <= rs_val;
        b <= rt_val;
      end
      if (alu_load) alu_out <= a + {{16{ir[15]}}, ir[15:0]};
      if (tmr_load)
        tmr <= TMR_LOAD;
      else if ((state == S_MEM) && (tmr != '0))
        tmr <= tmr - 1'b1;
      if (pc_inc)  pc <= pc + PC_W'(1);
      if (cnt_inc) store_cnt <= store_cnt + 16'd1;
    end
  end

  assign pc_o     = pc;
  assign dm_req   = (state == S_MEM);
  assign dm_addr  = alu_out;
  assign dm_wdata = b;
  assign busy     = (state != S_FETCH);

endmodule

// File: tb/tb_sw_datapath.sv
// Directed bench for sw_datapath: hand-computed store addresses/data, handshake timing,
// timeout abort, illegal opcode and mid-store reset.
module tb_sw_datapath;

  logic        clk = 1'b0;
  logic        rst, en;
  logic [31:0] pc_o, inst_i;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        dm_req, dm_ack, busy, illegal, timeout;
  logic [31:0] dm_addr, dm_wdata;
  logic [15:0] store_cnt;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] imem [0:15];
  assign inst_i = imem[pc_o[3:0]];

  always #5 clk = ~clk;

  sw_datapath #(.PC_W(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .en(en), .pc_o(pc_o), .inst_i(inst_i),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .dm_req(dm_req), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_ack(dm_ack),
    .busy(busy), .illegal(illegal), .timeout(timeout), .store_cnt(store_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [4:0] idx, input logic [31:0] val);
    rf_we = 1'b1; rf_waddr = idx; rf_wdata = val;
    @(negedge clk);
    rf_we = 1'b0;
  endtask

  // Start one instruction from FETCH; en is dropped in DECODE, which must not stall it.
  // Returns at the negedge of the first MEM cycle.
  task automatic to_mem();
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    chk("busy_decode", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("req_exec", {31'd0, dm_req}, 32'd0);
    @(negedge clk);
  endtask

  task automatic do_store(input string tag, input int wait_cyc,
                          input logic [31:0] ea, input logic [31:0] ed,
                          input logic [31:0] epc, input logic [15:0] ecnt);
    to_mem();
    for (int k = 0; k <= wait_cyc; k++) begin
      chk({tag, "_req"},   {31'd0, dm_req}, 32'd1);
      chk({tag, "_addr"},  dm_addr, ea);
      chk({tag, "_wdata"}, dm_wdata, ed);
      if (k == wait_cyc) dm_ack = 1'b1;
      @(negedge clk);
    end
    dm_ack = 1'b0;
    chk({tag, "_req_drop"}, {31'd0, dm_req}, 32'd0);
    chk({tag, "_busy"},     {31'd0, busy}, 32'd0);
    chk({tag, "_pc"},       pc_o, epc);
    chk({tag, "_cnt"},      {16'd0, store_cnt}, {16'd0, ecnt});
  endtask

  initial begin
    repeat (5000) @(posedge clk);
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 16; i++) imem[i] = 32'h0000_0000;
    imem[0] = 32'hAC22_0004;  // sw $2,4($1)
    imem[1] = 32'hAC64_FFFC;  // sw $4,-4($3)
    imem[2] = 32'hAC05_0008;  // sw $5,8($0)
    imem[3] = 32'hAC26_0000;  // sw $6,0($1)
    imem[4] = 32'hAC22_0004;  // no ack -> timeout
    imem[5] = 32'h8C22_0004;  // lw: illegal
    imem[6] = 32'hAC22_0004;  // reset during MEM

    rst = 1'b0; en = 1'b0; dm_ack = 1'b0;
    rf_we = 1'b0; rf_waddr = 5'd0; rf_wdata = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_pc",      pc_o, 32'd0);
    chk("rst_busy",    {31'd0, busy}, 32'd0);
    chk("rst_req",     {31'd0, dm_req}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    chk("rst_timeout", {31'd0, timeout}, 32'd0);
    chk("rst_cnt",     {16'd0, store_cnt}, 32'd0);
    rst = 1'b1;

    preload(5'd1, 32'd100);
    preload(5'd2, 32'hDEAD_BEEF);
    preload(5'd3, 32'd10);
    preload(5'd4, 32'h1234_5678);
    preload(5'd5, 32'h0000_0055);
    preload(5'd6, 32'hA5A5_A5A5);
    preload(5'd0, 32'hFFFF_FFFF);  // must be discarded

    chk("idle_pc", pc_o, 32'd0);
    do_store("t1", 0, 32'd104, 32'hDEAD_BEEF, 32'd1, 16'd1);

    // Ack while idle in FETCH must be ignored.
    dm_ack = 1'b1;
    repeat (2) @(negedge clk);
    dm_ack = 1'b0;
    chk("ack_idle_cnt",  {16'd0, store_cnt}, 32'd1);
    chk("ack_idle_busy", {31'd0, busy}, 32'd0);
    chk("en0_hold_pc",   pc_o, 32'd1);

    do_store("t2neg", 0, 32'd6, 32'h1234_5678, 32'd2, 16'd2);
    do_store("t2r0",  0, 32'd8, 32'h0000_0055, 32'd3, 16'd3);
    do_store("t3dly", 3, 32'd100, 32'hA5A5_A5A5, 32'd4, 16'd4);

    to_mem();
    for (int k = 0; k < 16; k++) begin
      chk("t4_req", {31'd0, dm_req}, 32'd1);
      chk("t4_tmo_low", {31'd0, timeout}, 32'd0);
      @(negedge clk);
    end
    chk("t4_timeout", {31'd0, timeout}, 32'd1);
    chk("t4_illegal", {31'd0, illegal}, 32'd0);
    chk("t4_req_drop", {31'd0, dm_req}, 32'd0);
    chk("t4_pc",  pc_o, 32'd5);
    chk("t4_cnt", {16'd0, store_cnt}, 32'd4);
    @(negedge clk);
    chk("t4_pulse_end", {31'd0, timeout}, 32'd0);

    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    chk("t5_req_dec", {31'd0, dm_req}, 32'd0);
    @(negedge clk);
    chk("t5_illegal", {31'd0, illegal}, 32'd1);
    chk("t5_timeout", {31'd0, timeout}, 32'd0);
    chk("t5_req",  {31'd0, dm_req}, 32'd0);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_pc",   pc_o, 32'd6);
    @(negedge clk);
    chk("t5_pulse_end", {31'd0, illegal}, 32'd0);
    chk("t5_cnt", {16'd0, store_cnt}, 32'd4);

    en = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_in_mem", {31'd0, dm_req}, 32'd1);
    chk("t6_addr",   dm_addr, 32'd104);
    rst = 1'b0;
    @(negedge clk);
    en = 1'b0;
    chk("t6_req",  {31'd0, dm_req}, 32'd0);
    chk("t6_pc",   pc_o, 32'd0);
    chk("t6_cnt",  {16'd0, store_cnt}, 32'd0);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_hold_pc",   pc_o, 32'd0);
    chk("t6_hold_busy", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
